instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the instruction ROM. Owns the program counter and drives the ROM word address.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 78 +++++++
 tb/tb_instr_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the fetch stage: word/address types, FIFO entry layout and
// the fetch control states.
package mips_pkg;

  typedef logic [31:0] word_t;
  typedef logic [29:0] waddr_t;

  typedef enum logic [1:0] {
    F_EMPTY = 2'd0,
    F_FILL  = 2'd1,
    F_FULL  = 2'd2
  } fetch_state_t;

  localparam word_t RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    word_t  instr;
    waddr_t addr;
  } fetch_entry_t;

  function automatic word_t byte_addr(input waddr_t a);
    return {a, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instruction, word address} pairs.
// Flush clears occupancy in one edge and wins over push/pop.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wr_entry,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is left unreset; occupancy is tracked by count_q and the head is gated downstream.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, reads the ROM combinationally, queues words
// in fetch_fifo and hands them to decode; redirects flush and restart fetch.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = RESET_VECTOR,
  parameter int    DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [29:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam int CW = $clog2(DEPTH) + 1;

  waddr_t        fpc_q, fpc_d;
  fetch_state_t  state_q, state_d;
  logic [CW-1:0] count, count_next;
  fetch_entry_t  head, wr_entry;
  logic          push, pop;
  logic [1:0]    unused_redir_lsbs;

  assign unused_redir_lsbs = redir_pc[1:0];

  assign out_valid = (state_q != F_EMPTY);
  assign pop       = out_valid & out_ready;
  assign push      = ~redir_valid & ((count < CW'(DEPTH)) | pop);
  assign wr_entry  = '{instr: imem_instr, addr: fpc_q};

  always_comb begin
    fpc_d = fpc_q;
    if (redir_valid) fpc_d = redir_pc[31:2];
    else if (push)   fpc_d = fpc_q + 1'b1;
  end

  // Next state follows the occupancy the FIFO will hold after this edge.
  always_comb begin
    count_next = redir_valid ? '0 : count + CW'(push) - CW'(pop);
    state_d    = F_FILL;
    if (redir_valid || count_next == '0) state_d = F_EMPTY;
    else if (count_next == CW'(DEPTH))   state_d = F_FULL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q   <= RESET_PC[31:2];
      state_q <= F_EMPTY;
    end else begin
      fpc_q   <= fpc_d;
      state_q <= state_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redir_valid),
    .wr_entry (wr_entry),
    .count    (count),
    .head     (head)
  );

  assign imem_pc      = fpc_q;
  assign out_instr    = out_valid ? head.instr : '0;
  assign out_pc       = out_valid ? byte_addr(head.addr) : '0;
  assign out_pc_plus4 = out_valid ? byte_addr(head.addr) + 32'd4 : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: scoreboard of expected delivered PCs,
// plus a second instance exercising PC wrap-around from a high reset vector.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_ready;
  logic        redir_valid;
  logic [31:0] redir_pc;

  logic [29:0] a_imem_pc;
  logic [31:0] a_imem_instr;
  logic        a_out_valid;
  logic [31:0] a_out_instr, a_out_pc, a_out_pc_plus4;

  logic [29:0] b_imem_pc;
  logic [31:0] b_imem_instr;
  logic        b_out_valid;
  logic [31:0] b_out_instr, b_out_pc, b_out_pc_plus4;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [29:0] a);
    return 32'hA000_0000 + {2'b00, a};
  endfunction

  assign a_imem_instr = rom(a_imem_pc);
  assign b_imem_instr = rom(b_imem_pc);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .imem_pc      (a_imem_pc),
    .imem_instr   (a_imem_instr),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .out_valid    (a_out_valid),
    .out_ready    (out_ready),
    .out_instr    (a_out_instr),
    .out_pc       (a_out_pc),
    .out_pc_plus4 (a_out_pc_plus4)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .imem_pc      (b_imem_pc),
    .imem_instr   (b_imem_instr),
    .redir_valid  (1'b0),
    .redir_pc     (32'h0),
    .out_valid    (b_out_valid),
    .out_ready    (1'b1),
    .out_instr    (b_out_instr),
    .out_pc       (b_out_pc),
    .out_pc_plus4 (b_out_pc_plus4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start_pc);
    sb.delete();
    for (int i = 0; i < 32; i++) sb.push_back(start_pc + 32'(4 * i));
  endtask

  // Called at a negedge: score a handshake that will complete on the coming edge.
  task automatic tick();
    logic [31:0] exp_pc;
    if (a_out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_underflow: observed pc %h expected no delivery", a_out_pc);
      end else begin
        exp_pc = sb.pop_front();
        check("sb_pc", a_out_pc, exp_pc);
        check("sb_instr", a_out_instr, rom(exp_pc[31:2]));
        check("sb_pc_plus4", a_out_pc_plus4, exp_pc + 32'd4);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    out_ready   = 1'b1;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    @(negedge clk);

    // Reset state
    check("rst_valid", 32'(a_out_valid), 32'd0);
    check("rst_pc", a_out_pc, 32'h0);
    check("rst_instr", a_out_instr, 32'h0);
    check("rst_pc_plus4", a_out_pc_plus4, 32'h0);
    check("rst_imem_pc", 32'(a_imem_pc), 32'h0);

    // 1: streaming from reset
    reset = 1'b0;
    sb_restart(32'h0);
    tick();
    check("t1_valid_edge1", 32'(a_out_valid), 32'd1);
    check("t1_first_pc", a_out_pc, 32'h0);
    repeat (4) tick();

    // 2: backpressure queues exactly DEPTH words and stalls the PC
    out_ready = 1'b0;
    pulse_reset();
    sb_restart(32'h0);
    repeat (5) tick();
    check("t2_imem_stall", 32'(a_imem_pc), 32'h2);
    check("t2_head_pc", a_out_pc, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_no_gap", 32'(a_out_valid), 32'd1);
    end

    // 3: redirect while full
    out_ready = 1'b0;
    repeat (3) tick();
    check("t3_imem_full", 32'(a_imem_pc), 32'h5);
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0043;
    tick();
    redir_valid = 1'b0;
    check("t3_flush_valid", 32'(a_out_valid), 32'd0);
    check("t3_redir_imem", 32'(a_imem_pc), 32'h10);
    check("t3_flush_pc", a_out_pc, 32'h0);
    sb_restart(32'h40);
    tick();
    check("t3_target_valid", 32'(a_out_valid), 32'd1);
    check("t3_target_pc", a_out_pc, 32'h40);

    // 4: redirect coincident with a pop at count==1
    out_ready = 1'b1;
    repeat (2) tick();
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0100;
    tick();
    redir_valid = 1'b0;
    sb_restart(32'h100);
    check("t4_flush_valid", 32'(a_out_valid), 32'd0);
    tick();
    check("t4_target_pc", a_out_pc, 32'h100);
    repeat (3) tick();

    // 5: async reset between edges with two words queued; 6: wrap on dut_b
    out_ready = 1'b0;
    repeat (2) tick();
    check("t5_pre_valid", 32'(a_out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t5_async_valid", 32'(a_out_valid), 32'd0);
    check("t5_async_imem", 32'(a_imem_pc), 32'h0);
    check("t5_async_pc", a_out_pc, 32'h0);
    check("t6_rst_imem", 32'(b_imem_pc), 32'h3FFF_FFFE);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    sb_restart(32'h0);
    check("t6_rst_valid", 32'(b_out_valid), 32'd0);
    tick();
    check("t6_pc0", b_out_pc, 32'hFFFF_FFF8);
    check("t6_plus4_0", b_out_pc_plus4, 32'hFFFF_FFFC);
    check("t6_instr0", b_out_instr, rom(30'h3FFF_FFFE));
    tick();
    check("t6_pc1", b_out_pc, 32'hFFFF_FFFC);
    check("t6_plus4_1", b_out_pc_plus4, 32'h0000_0000);
    tick();
    check("t6_pc2", b_out_pc, 32'h0000_0000);
    check("t6_plus4_2", b_out_pc_plus4, 32'h0000_0004);
    check("t6_instr2", b_out_instr, rom(30'h0));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
